// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Main control FSM for the X-RISC multicycle core. The FSM decodes the opcode and
// funct fields of the fetched instruction. It then steps the shared datapath
// through fetch, decode, execute, memory and writeback, one micro-operation per
// cycle. The datapath has one ALU, one memory port and one immediate extend unit.
//
// Configuration macro: XRISC_JAL_EN
//   defined   - JAL state present, opcode 1101111 decodes to JAL, immsrc=11 for jal
//               (the extend unit must decode J-type immediates on select 11).
//   undefined - 1101111 is an illegal opcode and immsrc never drives 11.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   op         in   instr[6:0]
//   funct3     in   instr[14:12]
//   funct7b5   in   instr[30]
//   zero       in   ALU zero flag
//   pcwrite    out  PC enable
//   adrsrc     out  memory address select (0 PC, 1 ALUOut)
//   memwrite   out  memory write enable
//   irwrite    out  IR / OldPC enable
//   regwrite   out  register file write enable
//   resultsrc  out  00 ALUOut, 01 Data, 10 ALUResult
//   alusrca    out  00 PC, 01 OldPC, 10 rs1
//   alusrcb    out  00 rs2, 01 ImmExt, 10 constant 4
//   immsrc     out  extend unit select (from op, valid in every state)
//   alucontrol out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal    out  sticky unsupported-opcode flag, cleared only by reset
//   dbg_state  out  current FSM state encoding, for observation only

module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
`ifdef XRISC_JAL_EN
    ,S_JAL     = 4'd10
`endif
  } state_t;

  // ALU operation class chosen by the state; funct decode refines it.
  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2
  } aluop_t;

  state_t     state;
  state_t     next;
  aluop_t     aluop;
  logic       illegal_q;
  logic       bad_op;
  state_t     decode_next;
  logic       pcwrite_raw;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic [2:0] funct_alu;

  // State register: reset forces FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Sticky illegal flag, captured at the end of the offending DECODE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             illegal_q <= 1'b0;
    else if (state == S_DECODE && bad_op)  illegal_q <= 1'b1;
  end

  // Opcode dispatch used by DECODE.
  always_comb begin
    decode_next = S_FETCH;
    bad_op      = 1'b0;
    case (op)
      7'b0000011,
      7'b0100011: decode_next = S_MEMADR;
      7'b0110011: decode_next = S_EXECR;
      7'b0010011: decode_next = S_EXECI;
      7'b1100011: decode_next = S_BEQ;
`ifdef XRISC_JAL_EN
      7'b1101111: decode_next = S_JAL;
`endif
      default:    bad_op      = 1'b1;
    endcase
  end

  // Next state and Moore outputs.
  always_comb begin
    next         = S_FETCH;
    pcwrite_raw  = 1'b0;
    adrsrc       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    resultsrc    = 2'b00;
    alusrca      = 2'b00;
    alusrcb      = 2'b00;
    aluop        = AOP_ADD;
    case (state)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        alusrcb     = 2'b10;
        resultsrc   = 2'b10;
        pcwrite_raw = 1'b1;
        next        = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed early into ALUOut.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        next    = decode_next;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        next   = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = 2'b01;
        regwrite_raw = 1'b1;
        next         = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_raw = 1'b1;
        next         = S_FETCH;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = AOP_FUNCT;
        next    = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = AOP_FUNCT;
        next    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        next         = S_FETCH;
      end
      S_BEQ: begin
        alusrca     = 2'b10;
        aluop       = AOP_SUB;
        pcwrite_raw = zero;
        next        = S_FETCH;
      end
`ifdef XRISC_JAL_EN
      S_JAL: begin
        // ALU produces OldPC+4 for the link register; ALUOut holds the target.
        alusrca     = 2'b01;
        alusrcb     = 2'b10;
        pcwrite_raw = 1'b1;
        next        = S_ALUWB;
      end
`endif
      default: next = S_FETCH;
    endcase
  end

  // Funct decode. Only R-type (op[5]=1) can select subtract.
  always_comb begin
    funct_alu = 3'b000;
    case (funct3)
      3'b000:  funct_alu = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      AOP_SUB:   alucontrol = 3'b001;
      AOP_FUNCT: alucontrol = funct_alu;
      default:   alucontrol = 3'b000;
    endcase
  end

  // Immediate format select, decoded straight from the opcode.
  always_comb begin
    immsrc = 2'b00;
    case (op)
      7'b0100011: immsrc = 2'b01;
      7'b1100011: immsrc = 2'b10;
`ifdef XRISC_JAL_EN
      7'b1101111: immsrc = 2'b11;
`endif
      default:    immsrc = 2'b00;
    endcase
  end

  // Enables are gated by reset combinationally so that none can rise
  // between reset assertion and the state register settling.
  assign pcwrite  = pcwrite_raw  & ~reset;
  assign memwrite = memwrite_raw & ~reset;
  assign irwrite  = irwrite_raw  & ~reset;
  assign regwrite = regwrite_raw & ~reset;

  // The flag is visible already in the DECODE cycle that sees the bad opcode.
  assign illegal  = ~reset & (illegal_q | (state == S_DECODE && bad_op));

  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .immsrc     (immsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  // state encodings
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                         ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10;

  // control word: {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb, alucontrol}
  localparam logic [13:0] C_RESET     = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000};
  localparam logic [13:0] C_FETCH     = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000};
  localparam logic [13:0] C_DECODE    = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [13:0] C_MEMADR    = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000};
  localparam logic [13:0] C_MEMREAD   = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [13:0] C_MEMWB     = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [13:0] C_MEMWRITE  = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [13:0] C_EXECR_ADD = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b000};
  localparam logic [13:0] C_EXECR_SUB = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001};
  localparam logic [13:0] C_EXECR_AND = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b010};
  localparam logic [13:0] C_EXECR_OR  = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b011};
  localparam logic [13:0] C_EXECR_SLT = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b101};
  localparam logic [13:0] C_EXECI_ADD = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000};
  localparam logic [13:0] C_EXECI_AND = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b010};
  localparam logic [13:0] C_ALUWB     = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [13:0] C_BEQ_T     = {5'b10000, 2'b00, 2'b10, 2'b00, 3'b001};
  localparam logic [13:0] C_BEQ_F     = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001};
  localparam logic [13:0] C_JAL       = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000};

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [3:0]  st;
    logic [13:0] ctl;
    logic [1:0]  imm;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  // scoreboard
  logic [20:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [20:0] actual_word();
    return {dbg_state, pcwrite, adrsrc, memwrite, irwrite, regwrite,
            resultsrc, alusrca, alusrcb, alucontrol, immsrc, illegal};
  endfunction

  task automatic check(input string name);
    logic [20:0] exp;
    logic [20:0] act;
    exp = exp_q.pop_front();
    act = actual_word();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got st=%0d ctl=%b imm=%b ill=%b, need st=%0d ctl=%b imm=%b ill=%b",
                  name, act[20:17], act[16:3], act[2:1], act[0],
                  exp[20:17], exp[16:3], exp[2:1], exp[0]);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                      input logic [3:0] st, input logic [13:0] ctl, input logic [1:0] imm,
                      input logic ill);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st; v.ctl = ctl; v.imm = imm; v.ill = ill;
    vq.push_back(v);
  endtask

  // Four-cycle ALU instruction: FETCH, DECODE, EXECR/EXECI, ALUWB.
  task automatic push_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [3:0] exst, input logic [13:0] exctl, input logic ill);
    push(o, f3, f7, 1'b0, FETCH,  C_FETCH,  2'b00, ill);
    push(o, f3, f7, 1'b0, DECODE, C_DECODE, 2'b00, ill);
    push(o, f3, f7, 1'b0, exst,   exctl,    2'b00, ill);
    push(o, f3, f7, 1'b0, ALUWB,  C_ALUWB,  2'b00, ill);
  endtask

  task automatic push_lw(input logic ill);
    push(OP_LW, 3'b010, 1'b0, 1'b0, FETCH,   C_FETCH,   2'b00, ill);
    push(OP_LW, 3'b010, 1'b0, 1'b0, DECODE,  C_DECODE,  2'b00, ill);
    push(OP_LW, 3'b010, 1'b0, 1'b0, MEMADR,  C_MEMADR,  2'b00, ill);
    push(OP_LW, 3'b010, 1'b0, 1'b0, MEMREAD, C_MEMREAD, 2'b00, ill);
    push(OP_LW, 3'b010, 1'b0, 1'b0, MEMWB,   C_MEMWB,   2'b00, ill);
  endtask

  initial begin
    // stimulus table
    push_lw(1'b0);
    push(OP_SW, 3'b010, 1'b0, 1'b0, FETCH,    C_FETCH,    2'b01, 1'b0);
    push(OP_SW, 3'b010, 1'b0, 1'b0, DECODE,   C_DECODE,   2'b01, 1'b0);
    push(OP_SW, 3'b010, 1'b0, 1'b0, MEMADR,   C_MEMADR,   2'b01, 1'b0);
    push(OP_SW, 3'b010, 1'b0, 1'b0, MEMWRITE, C_MEMWRITE, 2'b01, 1'b0);
    push_alu(OP_R, 3'b000, 1'b1, EXECR, C_EXECR_SUB, 1'b0);
    push_alu(OP_R, 3'b010, 1'b0, EXECR, C_EXECR_SLT, 1'b0);
    push_alu(OP_R, 3'b110, 1'b0, EXECR, C_EXECR_OR,  1'b0);
    push_alu(OP_R, 3'b111, 1'b1, EXECR, C_EXECR_AND, 1'b0);
    push_alu(OP_R, 3'b001, 1'b1, EXECR, C_EXECR_ADD, 1'b0);
    push_alu(OP_I, 3'b000, 1'b1, EXECI, C_EXECI_ADD, 1'b0);
    push_alu(OP_I, 3'b111, 1'b0, EXECI, C_EXECI_AND, 1'b0);
    push(OP_BEQ, 3'b000, 1'b0, 1'b1, FETCH,  C_FETCH,  2'b10, 1'b0);
    push(OP_BEQ, 3'b000, 1'b0, 1'b1, DECODE, C_DECODE, 2'b10, 1'b0);
    push(OP_BEQ, 3'b000, 1'b0, 1'b1, BEQ,    C_BEQ_T,  2'b10, 1'b0);
    push(OP_BEQ, 3'b000, 1'b0, 1'b0, FETCH,  C_FETCH,  2'b10, 1'b0);
    push(OP_BEQ, 3'b000, 1'b0, 1'b0, DECODE, C_DECODE, 2'b10, 1'b0);
    push(OP_BEQ, 3'b000, 1'b0, 1'b0, BEQ,    C_BEQ_F,  2'b10, 1'b0);
    // unsupported opcode: back to FETCH, flag sticks
    push(OP_BAD, 3'b000, 1'b0, 1'b0, FETCH,  C_FETCH,  2'b00, 1'b0);
    push(OP_BAD, 3'b000, 1'b0, 1'b0, DECODE, C_DECODE, 2'b00, 1'b1);
    push_lw(1'b1);
`ifdef XRISC_JAL_EN
    push(OP_JAL, 3'b000, 1'b0, 1'b0, FETCH,  C_FETCH,  2'b11, 1'b1);
    push(OP_JAL, 3'b000, 1'b0, 1'b0, DECODE, C_DECODE, 2'b11, 1'b1);
    push(OP_JAL, 3'b000, 1'b0, 1'b0, JAL,    C_JAL,    2'b11, 1'b1);
    push(OP_JAL, 3'b000, 1'b0, 1'b0, ALUWB,  C_ALUWB,  2'b11, 1'b1);
`else
    push(OP_JAL, 3'b000, 1'b0, 1'b0, FETCH,  C_FETCH,  2'b00, 1'b1);
    push(OP_JAL, 3'b000, 1'b0, 1'b0, DECODE, C_DECODE, 2'b00, 1'b1);
`endif

    // reset held for three cycles
    reset = 1'b1; op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_q.push_back({FETCH, C_RESET, 2'b00, 1'b0});
      check($sformatf("reset_hold_%0d", i));
    end
    reset = 1'b0;

    // table-driven walk; a fresh instruction starts right where the previous ended
    for (int i = 0; i < vq.size(); i++) begin
      op = vq[i].op; funct3 = vq[i].f3; funct7b5 = vq[i].f7; zero = vq[i].z;
      #1;
      exp_q.push_back({vq[i].st, vq[i].ctl, vq[i].imm, vq[i].ill});
      check($sformatf("vec_%0d_op%b_st%0d", i, vq[i].op, vq[i].st));
      step();
    end

    // reset mid-instruction: lw aborted in MEMWB, sticky flag cleared
    op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 4; i++) step();
    exp_q.push_back({MEMWB, C_MEMWB, 2'b00, 1'b1});
    check("pre_abort_memwb");
    #2 reset = 1'b1;
    #1;
    exp_q.push_back({FETCH, C_RESET, 2'b00, 1'b0});
    check("abort_async");
    step();
    exp_q.push_back({FETCH, C_RESET, 2'b00, 1'b0});
    check("abort_held");
    reset = 1'b0;
    #1;
    exp_q.push_back({FETCH, C_FETCH, 2'b00, 1'b0});
    check("after_abort_fetch");
    step();
    exp_q.push_back({DECODE, C_DECODE, 2'b00, 1'b0});
    check("after_abort_decode");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
